// File: rtl/capture_pkg.sv
// Shared types and defaults for the logic-analyzer sample-capture controller.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    localparam int CAP_ADDR_W_DEF    = 10;
    localparam int CAP_TIMEOUT_W_DEF = 24;

    // States in which qualified samples are written to the RAM.
    function automatic logic is_armed_state(input cap_state_e s);
        return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

    function automatic logic is_triggered_state(input cap_state_e s);
        return (s == ST_POST) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/capture_timeout.sv
// Auto-trigger timeout counter: counts qualified writes made while waiting for a trigger.
// Only instantiated when CAPTURE_TIMEOUT_EN is defined.
module capture_timeout
    import capture_pkg::*;
#(
    parameter int TIMEOUT_W = CAP_TIMEOUT_W_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // All-ones means the current write is the 2**TIMEOUT_W-th one; the caller
    // only consults this on a qualified write, so no dependence on inc here.
    assign at_limit = (cnt_q == {TIMEOUT_W{1'b1}});

endmodule

// File: rtl/capture_ctrl.sv
// Sample-capture controller: circular RAM writes, pre-trigger fill, post-trigger countdown.
// Optional auto-trigger timeout is built when CAPTURE_TIMEOUT_EN is defined.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W    = CAP_ADDR_W_DEF,
    parameter int TIMEOUT_W = CAP_TIMEOUT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [7:0]        data_in,
    input  logic              trigger_detected,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              timed_out
);

    cap_state_e        state_q, state_d;
    logic              se_d1_q, se_d1_d;
    logic [7:0]        d_d1_q, d_d1_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              timed_out_q, timed_out_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              armed_q, armed_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;

    logic qual_wr;
    logic timeout_clear;
    logic timeout_inc;
    logic timeout_fire;

    assign qual_wr = se_d1_q && is_armed_state(state_q);

    always_comb begin
        state_d       = state_q;
        se_d1_d       = sample_en;
        d_d1_d        = data_in;
        wr_ptr_d      = wr_ptr_q;
        wrapped_d     = wrapped_q;
        pre_cnt_d     = pre_cnt_q;
        post_cnt_d    = post_cnt_q;
        trig_addr_d   = trig_addr_q;
        timed_out_d   = timed_out_q;
        mem_we_d      = 1'b0;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        timeout_clear = 1'b0;
        timeout_inc   = 1'b0;

        if (abort) begin
            // Capture results (trig_addr, wrapped, wr_ptr) are left for readout.
            state_d = ST_IDLE;
        end else if (arm) begin
            // Restart from any state; the sample qualified this cycle is dropped.
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            trig_addr_d = '0;
            timed_out_d = 1'b0;
            if (pre_count == '0) begin
                state_d       = ST_WAIT_TRIG;
                timeout_clear = 1'b1;
            end else begin
                state_d = ST_PREFILL;
            end
        end else if (qual_wr) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = wr_ptr_q;
            mem_wdata_d = d_d1_q;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                wrapped_d = 1'b1;
            end

            case (state_q)
                ST_PREFILL: begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_q + 1'b1 == pre_count) begin
                        state_d       = ST_WAIT_TRIG;
                        timeout_clear = 1'b1;
                    end
                end
                ST_WAIT_TRIG: begin
                    timeout_inc = 1'b1;
                    if (trigger_detected || timeout_fire) begin
                        trig_addr_d = wr_ptr_q;
                        // A real trigger on the expiring write takes precedence.
                        timed_out_d = !trigger_detected;
                        if (post_count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            post_cnt_d = post_count;
                            state_d    = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they change with it.
    always_comb begin
        armed_d     = is_armed_state(state_d);
        triggered_d = is_triggered_state(state_d);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            se_d1_q     <= 1'b0;
            d_d1_q      <= '0;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            timed_out_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            se_d1_q     <= se_d1_d;
            d_d1_q      <= d_d1_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            timed_out_q <= timed_out_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    logic timeout_at_limit;

    capture_timeout #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (timeout_clear),
        .inc      (timeout_inc),
        .at_limit (timeout_at_limit)
    );

    assign timeout_fire = timeout_at_limit;
`else
    // No timeout: WAIT_TRIG waits forever and timed_out stays 0.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (^{TIMEOUT_W{1'b0}}) ^ timeout_clear ^ timeout_inc;
    assign timeout_fire       = 1'b0;
`endif

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign armed      = armed_q;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = wrapped_q ? wr_ptr_q : '0;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: table of capture scenarios plus hand-written corner sequences.
module tb_capture_ctrl;

    localparam int AW = 4;
    localparam int TW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          resetn;
    logic          arm;
    logic          abort;
    logic          sample_en;
    logic [7:0]    data_in;
    logic          trigger_detected;
    logic [AW-1:0] pre_count;
    logic [AW-1:0] post_count;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;
    logic          timed_out;

    capture_ctrl #(
        .ADDR_W    (AW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .arm              (arm),
        .abort            (abort),
        .sample_en        (sample_en),
        .data_in          (data_in),
        .trigger_detected (trigger_detected),
        .pre_count        (pre_count),
        .post_count       (post_count),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .armed            (armed),
        .triggered        (triggered),
        .done             (done),
        .trig_addr        (trig_addr),
        .start_addr       (start_addr),
        .timed_out        (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    pre;
        int    post;
        int    trig1;      // sample index (1-based) flagged by the trigger block, 0 = none
        int    trig2;
        bit    gap;        // strobe every other cycle
        int    exp_writes;
        int    exp_trig_addr;
        int    exp_start;
        int    exp_to;
    } vec_t;

    // Write monitor and rise detectors, sampled on the falling edge.
    logic [AW-1:0] wq_addr[$];
    logic [7:0]    wq_data[$];
    bit done_prev, trig_prev;
    bit done_rise_seen, trig_rise_seen;
    int done_rise_we, done_rise_addr, trig_rise_we, trig_rise_addr;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_waddr);
            wq_data.push_back(mem_wdata);
        end
        if (done && !done_prev) begin
            done_rise_seen = 1'b1;
            done_rise_we   = int'(mem_we);
            done_rise_addr = int'(mem_waddr);
        end
        if (triggered && !trig_prev) begin
            trig_rise_seen = 1'b1;
            trig_rise_we   = int'(mem_we);
            trig_rise_addr = int'(mem_waddr);
        end
        done_prev = done;
        trig_prev = triggered;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dat(input int k);
        int v;
        v = (k * 7 + 3) & 255;
        return v[7:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_rise_seen = 1'b0;
        trig_rise_seen = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int pend;
        int n;
        int bad;
        int first_bad;
        pre_count  = v.pre[AW-1:0];
        post_count = v.post[AW-1:0];
        sample_en  = 1'b0;
        trigger_detected = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        clear_mon();
        chk({v.name, ".armed_after_arm"}, int'(armed), 1);
        chk({v.name, ".done_after_arm"}, int'(done), 0);
        chk({v.name, ".trig_addr_after_arm"}, int'(trig_addr), 0);
        chk({v.name, ".start_addr_after_arm"}, int'(start_addr), 0);

        pend = 0;
        n = v.exp_writes + 3;
        for (int k = 1; k <= n; k++) begin
            sample_en        = 1'b1;
            data_in          = dat(k);
            trigger_detected = (pend != 0);
            pend = ((k == v.trig1) || (k == v.trig2)) ? 1 : 0;
            tick();
            if (v.gap) begin
                sample_en        = 1'b0;
                trigger_detected = (pend != 0);
                pend = 0;
                tick();
            end
        end
        sample_en        = 1'b0;
        trigger_detected = (pend != 0);
        tick();
        trigger_detected = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        chk({v.name, ".writes"}, wq_addr.size(), v.exp_writes);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < wq_addr.size(); i++) begin
            if (int'(wq_addr[i]) != (i % DEPTH) || wq_data[i] != dat(i + 1)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk({v.name, ".write_seq_first_bad"}, first_bad, -1);
        chk({v.name, ".done"}, int'(done), 1);
        chk({v.name, ".triggered"}, int'(triggered), 1);
        chk({v.name, ".armed"}, int'(armed), 0);
        chk({v.name, ".mem_we_idle"}, int'(mem_we), 0);
        chk({v.name, ".trig_addr"}, int'(trig_addr), v.exp_trig_addr);
        chk({v.name, ".start_addr"}, int'(start_addr), v.exp_start);
        chk({v.name, ".timed_out"}, int'(timed_out), v.exp_to);
        chk({v.name, ".done_rise_seen"}, int'(done_rise_seen), 1);
        chk({v.name, ".done_rise_we"}, done_rise_we, 1);
        chk({v.name, ".done_rise_addr"}, done_rise_addr, (v.exp_writes - 1) % DEPTH);
        chk({v.name, ".trig_rise_we"}, trig_rise_we, 1);
        chk({v.name, ".trig_rise_addr"}, trig_rise_addr, v.exp_trig_addr);
        $display("vec %s: writes=%0d trig_addr=%0d start_addr=%0d timed_out=%0d bad_writes=%0d",
                 v.name, wq_addr.size(), trig_addr, start_addr, timed_out, bad);
    endtask

    vec_t vecs[8];
    int   nvec;

    initial begin
        nvec = 0;
        vecs[nvec++] = '{"basic",       4, 3, 10, 0, 1'b0, 13,  9,  0, 0};
        vecs[nvec++] = '{"wrap",        4, 8, 20, 0, 1'b0, 28,  3, 12, 0};
        vecs[nvec++] = '{"prefill_trig",4, 2,  2, 6, 1'b0,  8,  5,  0, 0};
        vecs[nvec++] = '{"zero_post",   2, 0,  5, 0, 1'b1,  5,  4,  0, 0};
        vecs[nvec++] = '{"gap_nopre",   0, 1,  1, 0, 1'b1,  2,  0,  0, 0};
`ifdef CAPTURE_TIMEOUT_EN
        vecs[nvec++] = '{"timeout",     0, 2,  0, 0, 1'b0, 18, 15,  2, 1};
        vecs[nvec++] = '{"timeout_tie", 0, 2, 16, 0, 1'b0, 18, 15,  2, 0};
`endif

        resetn = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        sample_en = 1'b0;
        data_in = '0;
        trigger_detected = 1'b0;
        pre_count = '0;
        post_count = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("reset.mem_we", int'(mem_we), 0);
        chk("reset.mem_waddr", int'(mem_waddr), 0);
        chk("reset.mem_wdata", int'(mem_wdata), 0);
        chk("reset.armed", int'(armed), 0);
        chk("reset.triggered", int'(triggered), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.trig_addr", int'(trig_addr), 0);
        chk("reset.start_addr", int'(start_addr), 0);
        chk("reset.timed_out", int'(timed_out), 0);

        for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

        // Abort while in POST: writes stop the cycle after abort, done never rises.
        pre_count = '0;
        post_count = 4'd5;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        clear_mon();
        sample_en = 1'b1;
        data_in = dat(1);
        tick();
        data_in = dat(2);
        trigger_detected = 1'b1;
        tick();
        trigger_detected = 1'b0;
        data_in = dat(3);
        tick();
        chk("abort.triggered_before", int'(triggered), 1);
        data_in = dat(4);
        tick();
        abort = 1'b1;
        data_in = dat(5);
        tick();
        abort = 1'b0;
        chk("abort.mem_we_next", int'(mem_we), 0);
        chk("abort.armed", int'(armed), 0);
        chk("abort.triggered", int'(triggered), 0);
        data_in = dat(6);
        tick();
        data_in = dat(7);
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        chk("abort.writes", wq_addr.size(), 3);
        chk("abort.done", int'(done), 0);
        chk("abort.trig_addr_kept", int'(trig_addr), 0);
        $display("seq abort_in_post: writes=%0d done=%0d", wq_addr.size(), done);

        // arm and abort together: abort wins.
        pre_count = '0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_abort.armed_pre", int'(armed), 1);
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        clear_mon();
        chk("arm_abort.armed", int'(armed), 0);
        sample_en = 1'b1;
        data_in = dat(9);
        tick();
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        chk("arm_abort.writes", wq_addr.size(), 0);
        $display("seq arm_abort: armed=%0d writes=%0d", armed, wq_addr.size());

        // Trigger while se_d1=0 is ignored; then a qualified trigger is taken.
        pre_count = '0;
        post_count = 4'd1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        clear_mon();
        sample_en = 1'b1;
        data_in = dat(1);
        tick();
        sample_en = 1'b0;
        tick();
        trigger_detected = 1'b1;
        tick();
        trigger_detected = 1'b0;
        tick();
        chk("unqual_trig.triggered", int'(triggered), 0);
        chk("unqual_trig.armed", int'(armed), 1);
        sample_en = 1'b1;
        data_in = dat(2);
        tick();
        data_in = dat(3);
        trigger_detected = 1'b1;
        tick();
        sample_en = 1'b0;
        trigger_detected = 1'b0;
        tick();
        tick();
        chk("unqual_trig.done", int'(done), 1);
        chk("unqual_trig.trig_addr", int'(trig_addr), 1);
        chk("unqual_trig.writes", wq_addr.size(), 3);
        $display("seq unqualified_trigger: trig_addr=%0d writes=%0d", trig_addr, wq_addr.size());

        // Asynchronous reset in the middle of a capture.
        pre_count = 4'd4;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        sample_en = 1'b1;
        data_in = dat(1);
        tick();
        data_in = dat(2);
        tick();
        data_in = dat(3);
        tick();
        chk("async_rst.armed_before", int'(armed), 1);
        chk("async_rst.mem_we_before", int'(mem_we), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst.armed", int'(armed), 0);
        chk("async_rst.mem_we", int'(mem_we), 0);
        chk("async_rst.mem_waddr", int'(mem_waddr), 0);
        sample_en = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        $display("seq async_reset: armed=%0d mem_we=%0d", armed, mem_we);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
